// File: rtl/serial_shift_tx_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_shift_tx_pkg : state encoding and bit-order constants
// Rev 1.0
// ------------------------------------------------------------------
package serial_shift_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam bit BIT_ORDER_MSB = 1'b1;
  localparam bit BIT_ORDER_LSB = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARM   = ST_ARM,
    S_SHIFT = ST_SHIFT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_shift_tx_if.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_shift_tx_if : word handshake plus serial frame outputs
// Rev 1.0
// ------------------------------------------------------------------
interface serial_shift_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              sclk_out;
  logic              sdo;
  logic              cs_n;
  logic              busy;
  logic              done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, sclk_out, sdo, cs_n, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, sclk_out, sdo, cs_n, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/serial_shift_tx_sig_edge_detect.sv
`default_nettype none
// ------------------------------------------------------------------
// sig_edge_detect : registers a same-domain level, emits rise/fall pulses
// Rev 1.0
// ------------------------------------------------------------------
module sig_edge_detect (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_sig,
  output logic      o_rise,
  output logic      o_fall
);

  logic r_sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise =  i_sig & ~r_sig_q;
  assign o_fall = ~i_sig &  r_sig_q;

endmodule
`default_nettype wire

// File: rtl/serial_shift_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_shift_tx : accepts a word, shifts it out as a CPOL=0 frame
// Rev 1.0
// ------------------------------------------------------------------
module serial_shift_tx
  import serial_shift_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        sclk_in,
  serial_shift_tx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_bits_left, w_bits_left_nxt;
  logic              r_sdo, w_sdo_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_sclk_out, w_sclk_out_nxt;
  logic              r_done, w_done_nxt;

  logic              w_rise, w_fall;
  logic              w_load_bit, w_next_bit;
  logic [DATA_W-1:0] w_shifted;

  sig_edge_detect u_sclk_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (sclk_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Bit-order dependent taps: head bit of a fresh word, and the bit after the current head.
  assign w_load_bit = (MSB_FIRST == BIT_ORDER_MSB) ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
  assign w_next_bit = (MSB_FIRST == BIT_ORDER_MSB) ? r_shift[DATA_W-2]     : r_shift[1];
  assign w_shifted  = (MSB_FIRST == BIT_ORDER_MSB) ? (r_shift << 1)        : (r_shift >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_sdo       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk_out  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_left <= w_bits_left_nxt;
      r_sdo       <= w_sdo_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_sclk_out  <= w_sclk_out_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bits_left_nxt = r_bits_left;
    w_sdo_nxt       = r_sdo;
    w_cs_n_nxt      = r_cs_n;
    w_sclk_out_nxt  = r_sclk_out;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sclk_out_nxt = 1'b0;
        if (bus.tx_valid) begin
          w_shift_nxt     = bus.tx_data;
          w_sdo_nxt       = w_load_bit;
          w_cs_n_nxt      = 1'b0;
          w_bits_left_nxt = CNT_W'(DATA_W);
          w_state_nxt     = S_ARM;
        end
      end

      // Waiting for a fall guarantees the first serial clock gets a full high phase.
      S_ARM: begin
        w_sclk_out_nxt = 1'b0;
        if (w_fall) begin
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_sclk_out_nxt = sclk_in;
        if (w_rise && (r_bits_left != '0)) begin
          w_bits_left_nxt = r_bits_left - CNT_W'(1);
        end
        if (w_fall) begin
          if (r_bits_left != '0) begin
            w_shift_nxt = w_shifted;
            w_sdo_nxt   = w_next_bit;
          end else begin
            w_sclk_out_nxt = 1'b0;
            w_cs_n_nxt     = 1'b1;
            w_sdo_nxt      = 1'b0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.sclk_out = r_sclk_out;
  assign bus.sdo      = r_sdo;
  assign bus.cs_n     = r_cs_n;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_serial_shift_tx : directed bench for serial_shift_tx, both bit orders
// Rev 1.0
// ------------------------------------------------------------------
module tb_serial_shift_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_in = 1'b0;
  int   h = 2;
  logic div_en = 1'b1;
  int   div_cnt = 0;

  int checks = 0;
  int failures = 0;

  serial_shift_tx_if #(.DATA_W(8)) if0 ();
  serial_shift_tx_if #(.DATA_W(8)) if1 ();

  serial_shift_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .bus(if0)
  );
  serial_shift_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .bus(if1)
  );

  always #5 clk = ~clk;

  // Upstream divider model: sclk_in toggles every h clk cycles, forced low when stalled.
  always @(posedge clk) begin
    if (!div_en) begin
      div_cnt <= 0;
      sclk_in <= 1'b0;
    end else if (div_cnt >= h - 1) begin
      div_cnt <= 0;
      sclk_in <= ~sclk_in;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  logic sel = 1'b0;
  wire  m_sclk  = sel ? if1.sclk_out : if0.sclk_out;
  wire  m_sdo   = sel ? if1.sdo      : if0.sdo;
  wire  m_cs_n  = sel ? if1.cs_n     : if0.cs_n;
  wire  m_done  = sel ? if1.done     : if0.done;
  wire  m_ready = sel ? if1.tx_ready : if0.tx_ready;
  wire  m_busy  = sel ? if1.busy     : if0.busy;

  logic       mon_clear = 1'b0;
  int         cyc = 0;
  logic       prev_sclk = 1'b0;
  int         rise_cnt, frm_rises, done_cnt, done_cyc, first_rise_cyc;
  int         cs_glitch, cs_hi_run, gap_b2b;
  logic [7:0] rx_word;
  logic [7:0] frames [0:3];
  int         frame_rises [0:3];

  // Receiver model: captures sdo on every observed sclk_out rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (mon_clear) begin
      rise_cnt = 0; frm_rises = 0; done_cnt = 0; done_cyc = 0; first_rise_cyc = 0;
      cs_glitch = 0; cs_hi_run = 0; gap_b2b = -1; rx_word = 8'h00;
      for (int i = 0; i < 4; i++) begin
        frames[i] = 8'h00;
        frame_rises[i] = 0;
      end
    end else begin
      if (m_done) begin
        if (done_cnt < 4) begin
          frames[done_cnt] = rx_word;
          frame_rises[done_cnt] = frm_rises;
        end
        done_cnt++;
        done_cyc = cyc;
        frm_rises = 0;
        rx_word = 8'h00;
      end
      if (m_sclk && !prev_sclk) begin
        if (rise_cnt == 0) first_rise_cyc = cyc;
        rise_cnt++;
        frm_rises++;
        rx_word = {rx_word[6:0], m_sdo};
      end
      if (m_cs_n && !m_done && frm_rises > 0) cs_glitch++;
      if (m_cs_n) begin
        cs_hi_run++;
      end else begin
        if (cs_hi_run > 0 && done_cnt == 1 && gap_b2b < 0) gap_b2b = cs_hi_run;
        cs_hi_run = 0;
      end
    end
    prev_sclk = m_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
  endtask

  task automatic send(input bit which, input logic [7:0] d);
    @(negedge clk);
    if (which) begin
      if1.tx_data = d; if1.tx_valid = 1'b1;
    end else begin
      if0.tx_data = d; if0.tx_valid = 1'b1;
    end
    @(negedge clk);
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < 600 && done_cnt < n; i++) @(negedge clk);
    chk(tag, done_cnt, n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    if0.tx_valid = 1'b0; if0.tx_data = 8'h00;
    if1.tx_valid = 1'b0; if1.tx_data = 8'h00;
    idle(3);
    rst = 1'b0;

    chk("rst_cs_n", m_cs_n, 1);
    chk("rst_sclk", m_sclk, 0);
    chk("rst_sdo", m_sdo, 0);
    chk("rst_done", m_done, 0);
    chk("rst_ready", m_ready, 1);
    chk("rst_busy", m_busy, 0);

    // MSB first, H=2; tx_data disturbed after the handshake must not matter.
    clear_mon();
    send(1'b0, 8'hC4);
    chk("t1_ready_low", m_ready, 0);
    chk("t1_busy_high", m_busy, 1);
    if0.tx_data = 8'hFF;
    wait_done("t1_done_seen", 1);
    idle(10);
    chk("t1_done_single", done_cnt, 1);
    chk("t1_word", frames[0], 8'hC4);
    chk("t1_rises", frame_rises[0], 8);
    chk("t1_cs_glitch", cs_glitch, 0);
    // done lands 2*H*W after SHIFT entry; the first sclk_out rise shows H cycles after it.
    chk("t1_timing", done_cyc - first_rise_cyc, 30);
    chk("t1_cs_idle", m_cs_n, 1);
    chk("t1_sdo_idle", m_sdo, 0);

    // LSB first: 0xC4 goes out 0,0,1,0,0,0,1,1.
    sel = 1'b1;
    clear_mon();
    send(1'b1, 8'hC4);
    wait_done("t2_done_seen", 1);
    chk("t2_word", frames[0], 8'h23);
    chk("t2_rises", frame_rises[0], 8);
    sel = 1'b0;

    // Back-to-back with tx_valid held.
    clear_mon();
    @(negedge clk);
    if0.tx_data = 8'hC4; if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_data = 8'h0F;
    wait_done("t3_first_done", 1);
    for (int i = 0; i < 20 && m_ready; i++) @(negedge clk);
    if0.tx_valid = 1'b0;
    wait_done("t3_second_done", 2);
    chk("t3_word0", frames[0], 8'hC4);
    chk("t3_word1", frames[1], 8'h0F);
    chk("t3_rises1", frame_rises[1], 8);
    chk("t3_cs_gap", gap_b2b, 1);
    chk("t3_cs_glitch", cs_glitch, 0);

    // Reset after the third rise.
    clear_mon();
    send(1'b0, 8'hC4);
    for (int i = 0; i < 200 && rise_cnt < 3; i++) @(negedge clk);
    chk("t4_three_rises", rise_cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_cs_n", m_cs_n, 1);
    chk("t4_sclk", m_sclk, 0);
    chk("t4_sdo", m_sdo, 0);
    chk("t4_ready", m_ready, 1);
    chk("t4_busy", m_busy, 0);
    idle(60);
    chk("t4_no_done", done_cnt, 0);
    clear_mon();
    send(1'b0, 8'hC4);
    wait_done("t4_resend_done", 1);
    chk("t4_resend_word", frames[0], 8'hC4);

    // Stalled divider: parked in ARM until sclk_in resumes.
    clear_mon();
    div_en = 1'b0;
    idle(4);
    send(1'b0, 8'hC4);
    idle(20);
    chk("t5_cs_n", m_cs_n, 0);
    chk("t5_sclk", m_sclk, 0);
    chk("t5_ready", m_ready, 0);
    chk("t5_busy", m_busy, 1);
    chk("t5_no_rise", rise_cnt, 0);
    div_en = 1'b1;
    wait_done("t5_done_seen", 1);
    chk("t5_word", frames[0], 8'hC4);
    chk("t5_rises", frame_rises[0], 8);

    // Fastest divider, H=1.
    h = 1;
    idle(4);
    clear_mon();
    send(1'b0, 8'hA5);
    wait_done("t6_done_seen", 1);
    chk("t6_word", frames[0], 8'hA5);
    chk("t6_rises", frame_rises[0], 8);
    chk("t6_timing", done_cyc - first_rise_cyc, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
